// File: rtl/result_serializer_if.sv
// Byte-stream link from the result serializer to the output pins.
// The master drives data_out/data_valid; the slave answers with data_ready.
interface result_serializer_if #(
  parameter int unsigned BW = 8
);
  logic [BW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/result_serializer.sv
// Result serializer: captures the N_ELEM-element result matrix in one cycle and
// streams it out least-significant byte first over a valid/ready handshake.
module result_serializer #(
  parameter int unsigned N_ELEM = 9,
  parameter int unsigned CW     = 18,
  parameter int unsigned BW     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW-1:0]        C [0:N_ELEM-1],
  result_serializer_if.master  tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NB  = (CW + BW - 1) / BW;
  localparam int unsigned EW  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned BYW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [EW-1:0]  ELEM_LAST = EW'(N_ELEM - 1);
  localparam logic [BYW-1:0] BYTE_LAST = BYW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     shadow [0:N_ELEM-1];
  logic [EW-1:0]     elem;
  logic [BYW-1:0]    byte_idx;
  logic              capture;
  logic              xfer;
  logic              last;
  logic [NB*BW-1:0]  padded;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode: capture from IDLE/DONE, advance on transfer.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    xfer       = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        xfer = tx.data_ready;
        last = xfer && (elem == ELEM_LAST) && (byte_idx == BYTE_LAST);
        if (last) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow capture and element/byte counters. The counters stop on the final
  // transfer instead of wrapping, so the output byte holds its last value in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_ELEM; i++) begin
        shadow[i] <= '0;
      end
      elem     <= '0;
      byte_idx <= '0;
    end else if (capture) begin
      shadow   <= C;
      elem     <= '0;
      byte_idx <= '0;
    end else if (xfer && !last) begin
      if (byte_idx == BYTE_LAST) begin
        byte_idx <= '0;
        elem     <= elem + EW'(1);
      end else begin
        byte_idx <= byte_idx + BYW'(1);
      end
    end
  end

  // Output byte selection with zero fill above CW; status flags from state.
  always_comb begin
    padded            = '0;
    padded[CW-1:0]    = shadow[elem];
    tx.data_out       = padded[32'(byte_idx) * BW +: BW];
    tx.data_valid     = (state == SEND);
    busy              = (state == SEND);
    done              = (state == DONE);
  end

endmodule
